// File: rtl/i2c_sensor_poller.sv
// rtl/i2c_sensor_poller.sv - sequences i2c_master commands to read a 16-bit sensor register
// Pointer write, repeated-start MSB/LSB read, with NACK and busy-watchdog error reporting.
module i2c_sensor_poller #(
    parameter logic [6:0] ADDR        = 7'b1001000,
    parameter logic [7:0] PTR_REG     = 8'h00,
    parameter int         POLL_PERIOD = 5_000_000,
    parameter int         TIMEOUT     = 1_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        poll_en,
    input  logic        start,
    output logic        i2c_ena,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [7:0]  i2c_data_wr,
    input  logic        i2c_busy,
    input  logic [7:0]  i2c_data_rd,
    input  logic        i2c_ack_error,
    output logic [15:0] sample,
    output logic        sample_valid,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        active
);
    localparam int PW = $clog2(POLL_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_PERIOD - 1);
    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t r_state, w_next;

    logic          r_busy_q;
    logic [1:0]    r_rise_cnt, r_fall_cnt;
    logic [PW-1:0] r_poll_cnt;
    logic [TW-1:0] r_wdog;
    logic [7:0]    r_msb, r_lsb;
    logic          r_ena, r_rw, r_sample_valid, r_err, r_active;
    logic [1:0]    r_err_code;
    logic [15:0]   r_sample;

    logic       w_rise, w_fall, w_edge, w_trigger, w_timeout;
    logic       w_ena_d, w_rw_d, w_sample_valid_d, w_err_d;
    logic [1:0] w_err_code_d;

    assign w_rise    = i2c_busy & ~r_busy_q;
    assign w_fall    = ~i2c_busy & r_busy_q;
    assign w_edge    = w_rise | w_fall;
    assign w_trigger = (r_state == S_IDLE) && (start || (poll_en && (r_poll_cnt == POLL_LAST)));
    // Any busy edge restarts the watchdog, so an edge always beats a coincident expiry.
    assign w_timeout = ((r_state == S_RUN) || ((r_state == S_DRAIN) && i2c_busy))
                       && (r_wdog == WDOG_LAST) && !w_edge;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_trigger) w_next = S_RUN;
            S_RUN: begin
                if (w_fall && i2c_ack_error)      w_next = S_DRAIN;
                else if (w_fall && r_fall_cnt == 2'd2) w_next = S_DONE;
                else if (w_timeout)                w_next = S_IDLE;
            end
            S_DRAIN: if (!i2c_busy || w_timeout) w_next = S_IDLE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_ena_d          = r_ena;
        w_rw_d           = r_rw;
        w_sample_valid_d = 1'b0;
        w_err_d          = 1'b0;
        w_err_code_d     = r_err_code;
        case (r_state)
            S_IDLE: begin
                w_ena_d = w_trigger;
                if (w_trigger) w_rw_d = 1'b0;
            end
            S_RUN: begin
                if (w_rise && r_rise_cnt == 2'd0) w_rw_d  = 1'b1;
                if (w_rise && r_rise_cnt == 2'd2) w_ena_d = 1'b0;
                if (w_fall && i2c_ack_error) begin
                    w_ena_d      = 1'b0;
                    w_err_code_d = 2'b01;
                end
            end
            S_DRAIN: if (!i2c_busy) w_err_d = 1'b1;
            S_DONE:  w_sample_valid_d = 1'b1;
            default: ;
        endcase
        if (w_timeout) begin
            w_ena_d      = 1'b0;
            w_err_code_d = 2'b10;
            w_err_d      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= S_IDLE;
            r_ena          <= 1'b0;
            r_rw           <= 1'b0;
            r_sample       <= '0;
            r_sample_valid <= 1'b0;
            r_err          <= 1'b0;
            r_err_code     <= 2'b00;
            r_active       <= 1'b0;
        end else begin
            r_state        <= w_next;
            r_ena          <= w_ena_d;
            r_rw           <= w_rw_d;
            r_sample_valid <= w_sample_valid_d;
            r_err          <= w_err_d;
            r_err_code     <= w_err_code_d;
            r_active       <= (w_next != S_IDLE);
            if (r_state == S_DONE) r_sample <= {r_msb, r_lsb};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy_q   <= 1'b0;
            r_rise_cnt <= 2'd0;
            r_fall_cnt <= 2'd0;
            r_poll_cnt <= '0;
            r_wdog     <= '0;
            r_msb      <= 8'h00;
            r_lsb      <= 8'h00;
        end else begin
            r_busy_q <= i2c_busy;
            // Cleared outside IDLE so auto-poll spacing is measured from IDLE entry.
            if (r_state == S_IDLE && poll_en && !w_trigger) r_poll_cnt <= r_poll_cnt + PW'(1);
            else                                            r_poll_cnt <= '0;
            if (r_state == S_IDLE) begin
                r_rise_cnt <= 2'd0;
                r_fall_cnt <= 2'd0;
            end else begin
                if (w_rise) r_rise_cnt <= r_rise_cnt + 2'd1;
                if (w_fall) r_fall_cnt <= r_fall_cnt + 2'd1;
            end
            if ((r_state == S_RUN || r_state == S_DRAIN) && !w_edge) r_wdog <= r_wdog + TW'(1);
            else                                                     r_wdog <= '0;
            if (r_state == S_RUN && w_fall && !i2c_ack_error) begin
                if (r_fall_cnt == 2'd1) r_msb <= i2c_data_rd;
                if (r_fall_cnt == 2'd2) r_lsb <= i2c_data_rd;
            end
        end
    end

    assign i2c_ena      = r_ena;
    assign i2c_addr     = ADDR;
    assign i2c_rw       = r_rw;
    assign i2c_data_wr  = PTR_REG;
    assign sample       = r_sample;
    assign sample_valid = r_sample_valid;
    assign err          = r_err;
    assign err_code     = r_err_code;
    assign active       = r_active;
endmodule

// File: tb/tb_i2c_sensor_poller.sv
// tb/tb_i2c_sensor_poller.sv - directed self-checking bench for i2c_sensor_poller
`timescale 1ns/1ps
module tb_i2c_sensor_poller;
    localparam logic [6:0] ADDR = 7'b1001000;
    localparam logic [7:0] PTR  = 8'hA5;
    localparam int         POLL = 50;
    localparam int         TMO  = 100;

    logic        clk = 1'b0;
    logic        reset_n, poll_en, start;
    logic        i2c_ena, i2c_rw, i2c_busy, i2c_ack_error;
    logic [6:0]  i2c_addr;
    logic [7:0]  i2c_data_wr, i2c_data_rd;
    logic [15:0] sample;
    logic        sample_valid, err, active;
    logic [1:0]  err_code;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_sv = 0, n_err = 0, n_ena_rise = 0;
    logic ena_prev = 1'b0;
    int   idle_run = 0, dw_n = 0;
    int   dwell [0:15];

    i2c_sensor_poller #(.ADDR(ADDR), .PTR_REG(PTR), .POLL_PERIOD(POLL), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .poll_en(poll_en), .start(start),
        .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_wr(i2c_data_wr),
        .i2c_busy(i2c_busy), .i2c_data_rd(i2c_data_rd), .i2c_ack_error(i2c_ack_error),
        .sample(sample), .sample_valid(sample_valid), .err(err), .err_code(err_code),
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Pulse counters and IDLE dwell lengths, sampled mid-cycle.
    always @(negedge clk) begin
        if (sample_valid) n_sv++;
        if (err) n_err++;
        if (i2c_ena && !ena_prev) n_ena_rise++;
        ena_prev = i2c_ena;
        if (!active) idle_run++;
        else begin
            if (idle_run != 0 && dw_n < 16) begin
                dwell[dw_n] = idle_run;
                dw_n++;
            end
            idle_run = 0;
        end
    end

    // Behavioural i2c_master: three byte commands, busy high 8 cycles, gap 4 cycles.
    task automatic model_xact(input logic [7:0] msb, input logic [7:0] lsb, input int nack_at,
                              input int stop_at, input int start_at, output logic [2:0] rw_seen);
        int n;
        rw_seen = 3'b000;
        n = 0;
        while (!i2c_ena && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq("ena_wait", i2c_ena, 1'b1);
        if (!i2c_ena) return;
        i2c_ack_error = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            check_eq("ena_before_rise", i2c_ena, 1'b1);
            rw_seen[k-1] = i2c_rw;
            i2c_busy = 1'b1;
            if (k == stop_at) return;
            repeat (8) @(negedge clk);
            if (k == start_at) begin
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
            if (k == 3) check_eq("ena_drop_rise3", i2c_ena, 1'b0);
            i2c_ack_error = (k == nack_at);
            i2c_data_rd   = (k == 2) ? msb : ((k == 3) ? lsb : 8'h00);
            i2c_busy      = 1'b0;
            if (k == nack_at || k == 3) return;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [2:0] rw;
        int sv0, er0, en0, d0, c;
        reset_n = 1'b0; poll_en = 1'b0; start = 1'b0;
        i2c_busy = 1'b0; i2c_data_rd = 8'h00; i2c_ack_error = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_ena", i2c_ena, 1'b0);
        check_eq("rst_rw", i2c_rw, 1'b0);
        check_eq("rst_data_wr", i2c_data_wr, PTR);
        check_eq("rst_addr", i2c_addr, ADDR);
        check_eq("rst_sample", sample, 16'h0000);
        check_eq("rst_sv", sample_valid, 1'b0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_err_code", err_code, 2'b00);
        check_eq("rst_active", active, 1'b0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);

        // Single read
        sv0 = n_sv; er0 = n_err;
        pulse_start();
        check_eq("trig_ena", i2c_ena, 1'b1);
        check_eq("trig_rw", i2c_rw, 1'b0);
        check_eq("trig_active", active, 1'b1);
        model_xact(8'h1A, 8'hC0, 0, 0, 0, rw);
        @(negedge clk);
        check_eq("sv_lat1", sample_valid, 1'b0);
        check_eq("done_active", active, 1'b1);
        @(negedge clk);
        check_eq("sv_lat2", sample_valid, 1'b1);
        check_eq("single_sample", sample, 16'h1AC0);
        check_eq("sv_end_active", active, 1'b0);
        @(negedge clk);
        check_eq("sv_one_cycle", sample_valid, 1'b0);
        check_eq("single_rw_seq", rw, 3'b110);
        check_eq("single_sv_cnt", n_sv - sv0, 1);
        check_eq("single_err_cnt", n_err - er0, 0);

        // Address NACK at fall 1
        sv0 = n_sv; er0 = n_err;
        pulse_start();
        model_xact(8'h55, 8'h66, 1, 0, 0, rw);
        @(negedge clk);
        check_eq("nack_ena", i2c_ena, 1'b0);
        check_eq("nack_code_early", err_code, 2'b01);
        check_eq("nack_err_wait", err, 1'b0);
        @(negedge clk);
        check_eq("nack_err", err, 1'b1);
        check_eq("nack_code", err_code, 2'b01);
        check_eq("nack_sample", sample, 16'h1AC0);
        check_eq("nack_active", active, 1'b0);
        i2c_ack_error = 1'b0;
        @(negedge clk);
        check_eq("nack_err_pulse", err, 1'b0);
        check_eq("nack_err_cnt", n_err - er0, 1);
        check_eq("nack_sv_cnt", n_sv - sv0, 0);

        // Timeout: busy stuck high after rise 1
        pulse_start();
        model_xact(8'h00, 8'h00, 0, 1, 0, rw);
        @(posedge clk);
        c = 0;
        while (!err && c < 300) begin
            @(posedge clk); #1;
            c++;
        end
        check_eq("tmo_cycles", c, TMO);
        check_eq("tmo_code", err_code, 2'b10);
        check_eq("tmo_active", active, 1'b0);
        check_eq("tmo_ena", i2c_ena, 1'b0);
        check_eq("tmo_sample", sample, 16'h1AC0);
        @(posedge clk); #1;
        check_eq("tmo_err_pulse", err, 1'b0);
        i2c_busy = 1'b0;
        repeat (3) @(negedge clk);

        // Start pulsed during RUN is ignored
        sv0 = n_sv; en0 = n_ena_rise;
        pulse_start();
        model_xact(8'h12, 8'h34, 0, 0, 2, rw);
        repeat (3) @(negedge clk);
        check_eq("ign_sample", sample, 16'h1234);
        repeat (100) @(negedge clk);
        check_eq("ign_ena_rises", n_ena_rise - en0, 1);
        check_eq("ign_sv_cnt", n_sv - sv0, 1);
        check_eq("ign_active", active, 1'b0);
        check_eq("ign_rw_seq", rw, 3'b110);

        // Auto-poll
        sv0 = n_sv; en0 = n_ena_rise; d0 = dw_n;
        poll_en = 1'b1;
        c = 0;
        while (!i2c_ena && c < 300) begin
            @(negedge clk);
            c++;
        end
        check_eq("poll_first", c, POLL);
        model_xact(8'h01, 8'h02, 0, 0, 0, rw);
        model_xact(8'h03, 8'h04, 0, 0, 0, rw);
        model_xact(8'hBE, 8'hEF, 0, 0, 0, rw);
        poll_en = 1'b0;
        repeat (120) @(negedge clk);
        check_eq("poll_sv_cnt", n_sv - sv0, 3);
        check_eq("poll_ena_rises", n_ena_rise - en0, 3);
        check_eq("poll_dw_n", dw_n - d0, 3);
        check_eq("poll_dwell2", dwell[(d0 + 1) % 16], POLL);
        check_eq("poll_dwell3", dwell[(d0 + 2) % 16], POLL);
        check_eq("poll_sample", sample, 16'hBEEF);

        // Reset after rise 2
        pulse_start();
        model_xact(8'h00, 8'h00, 0, 2, 0, rw);
        repeat (3) @(negedge clk);
        check_eq("mrst_pre_rw", i2c_rw, 1'b1);
        check_eq("mrst_pre_active", active, 1'b1);
        #2;
        reset_n  = 1'b0;
        i2c_busy = 1'b0;
        #1;
        check_eq("mrst_ena", i2c_ena, 1'b0);
        check_eq("mrst_rw", i2c_rw, 1'b0);
        check_eq("mrst_data_wr", i2c_data_wr, PTR);
        check_eq("mrst_sample", sample, 16'h0000);
        check_eq("mrst_sv", sample_valid, 1'b0);
        check_eq("mrst_err", err, 1'b0);
        check_eq("mrst_err_code", err_code, 2'b00);
        check_eq("mrst_active", active, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        sv0 = n_sv;
        pulse_start();
        model_xact(8'h7E, 8'h31, 0, 0, 0, rw);
        repeat (4) @(negedge clk);
        check_eq("post_rst_sample", sample, 16'h7E31);
        check_eq("post_rst_rw_seq", rw, 3'b110);
        check_eq("post_rst_sv_cnt", n_sv - sv0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
